led_seq_ctrl: RTL and testbench
===============================

// Module: led_seq_ctrl
// PURPOSE
// - Pattern sequencer for the iCEstick LED bank: prescales clk to a step tick, drives a one-hot/all-on
//   pattern on NUM_LED ring LEDs plus the centre power LED. Mode changes arrive via valid/ready
//   handshake (from button debouncer or UART cmd block) and take effect only on a step boundary.
// PARAMETERS
// - DIV_W    20  prescaler width; one step tick every 2^DIV_W clk cycles
// - NUM_LED  4   ring LED count (>=2)
// PORTS
// - clk          in   1        system clock (12 MHz on board)
// - rst_n        in   1        asynchronous, active-low reset
// - mode_valid   in   1        mode request valid
// - mode         in   2        requested mode: 0 FWD, 1 REV, 2 BOUNCE, 3 BLINK
// - mode_ready   out  1        request slot free; transfer when valid&ready at posedge clk
// - pause        in   1        1 = freeze prescaler and pattern
// - led          out  NUM_LED  ring LED drive, active-high
// - led_pwr      out  1        centre LED drive
// - step_tick    out  1        1-cycle pulse per step
// BEHAVIOUR
// - Reset: div=0, pos=0, state=FWD, pending empty, led=1 (LED0 only), led_pwr=1, step_tick=0,
//   mode_ready=1.
// - Prescaler: div increments each cycle unless pause; step_tick=1 (registered) in the cycle after
//   div wraps all-ones->0. Pattern updates on the same edge step_tick rises; led/led_pwr registered.
// - pause=1: div, pos, state, led held; no step_tick. Handshake still accepted.
// - Handshake: mode_ready=~pending_valid. Accept latches mode, sets pending_valid. Held until the next
//   step, which applies it and clears pending_valid (mode_ready back to 1 next cycle). valid while
//   ready=0 not accepted; requester must hold. Accept and apply in same cycle impossible (ready=0).
// - States: FWD, REV, BOUNCE_UP, BOUNCE_DN, BLINK_ON, BLINK_OFF.
// - On step with pending: enter new mode's initial state, ignoring current position:
//   FWD->pos=0, REV->pos=NUM_LED-1, BOUNCE->BOUNCE_UP pos=0, BLINK->BLINK_ON.
//   Re-requesting the current mode restarts it.
// - On step without pending:
//   FWD: pos=(pos==NUM_LED-1)?0:pos+1.  REV: pos=(pos==0)?NUM_LED-1:pos-1.
//   BOUNCE_UP: pos+1; at NUM_LED-1 -> BOUNCE_DN (pos NUM_LED-1 shown once, no repeat).
//   BOUNCE_DN: pos-1; at 0 -> BOUNCE_UP. Seq N=4: 0,1,2,3,2,1,0,1,...
//   BLINK_ON<->BLINK_OFF toggle each step.
// - led: one-hot(pos) in FWD/REV/BOUNCE; all ones in BLINK_ON; all zeros in BLINK_OFF.
// - pos width $clog2(NUM_LED); wrap explicit, never relies on power-of-2 overflow.
// - Async reset mid-pattern or with pending request: immediate return to reset values; pending dropped.
// CONFIGURATION
// - LED_HEARTBEAT_EN defined: led_pwr toggles each time a pattern cycle completes (FWD pos wraps
//   NUM_LED-1->0, REV pos wraps 0->NUM_LED-1, BOUNCE reaches pos 0 from DN, BLINK enters BLINK_ON);
//   a mode-apply step does not toggle.
// - Not defined: led_pwr constant 1 after reset; no heartbeat logic synthesised.
// TESTING (bench DIV_W=2, NUM_LED=4: step every 4 cycles)
// - Release rst_n, run 5 steps -> step_tick every 4th cycle; led 0001,0010,0100,1000,0001,0010.
// - mode_valid=1 mode=2 mid-interval -> ready drops next cycle, stays 0 until step; led then 0001, then
//   0010,0100,1000,0100,0010,0001; ready=1 the cycle after apply.
// - Second request (mode=1) while ready=0 -> not accepted; held valid accepted after apply; next step
//   led=1000, then 0100.
// - mode=3 applied -> led 1111,0000,1111 on successive steps; pause=1 for 20 cycles -> no step_tick,
//   led frozen, div held; pause=0 -> resumes from held div.
// - Assert rst_n=0 mid-BOUNCE with pending request -> led=0001, mode_ready=1, led_pwr=1 immediately.
// - LED_HEARTBEAT_EN: FWD 8 steps -> led_pwr toggles on 4th and 8th step; undefined -> led_pwr stays 1.

Source files
------------

// File: rtl/led_seq_ctrl_if.sv
// Mode-request handshake between a requester (button debouncer or UART command block)
// and the LED sequencer. A transfer happens when mode_valid & mode_ready at posedge clk.
interface led_seq_ctrl_if;
    logic       mode_valid;
    logic [1:0] mode;        // 0 FWD, 1 REV, 2 BOUNCE, 3 BLINK
    logic       mode_ready;

    modport master (
        output mode_valid,
        output mode,
        input  mode_ready
    );

    modport slave (
        input  mode_valid,
        input  mode,
        output mode_ready
    );
endinterface

// File: rtl/led_seq_ctrl.sv
// LED pattern sequencer for the iCEstick LED bank.
// A free-running prescaler produces one step every 2^DIV_W clocks. On each step the ring
// pattern advances (FWD / REV / BOUNCE / BLINK), or a pending mode request is applied.
// Mode requests arrive over led_seq_ctrl_if and wait in a one-entry slot until the next step.
// Optional feature macro: LED_HEARTBEAT_EN - led_pwr toggles whenever a pattern cycle
// completes; when undefined led_pwr is tied high.
module led_seq_ctrl #(
    parameter int unsigned DIV_W   = 20,
    parameter int unsigned NUM_LED = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    led_seq_ctrl_if.slave      req,
    input  logic               pause,
    output logic [NUM_LED-1:0] led,
    output logic               led_pwr,
    output logic               step_tick
);

    localparam int unsigned      POS_W   = $clog2(NUM_LED);
    localparam logic [POS_W-1:0] POS_MAX = POS_W'(NUM_LED - 1);
    localparam logic [POS_W-1:0] POS_ONE = POS_W'(1);

    typedef enum logic [2:0] {
        StFwd,
        StRev,
        StBounceUp,
        StBounceDn,
        StBlinkOn,
        StBlinkOff
    } state_e;

    logic [DIV_W-1:0]   div_q, div_d;
    logic [POS_W-1:0]   pos_q, pos_d;
    state_e             state_q, state_d;
    logic               pend_valid_q, pend_valid_d;
    logic [1:0]         pend_mode_q, pend_mode_d;
    logic [NUM_LED-1:0] led_q, led_d;
    logic               step_tick_q;
    logic               step;

    // A step happens on the edge where the prescaler wraps all-ones -> 0.
    assign step = ~pause & (div_q == '1);

    assign req.mode_ready = ~pend_valid_q;
    assign led            = led_q;
    assign step_tick      = step_tick_q;

    // Next-state: prescaler, request slot and pattern FSM.
    always_comb begin
        div_d        = div_q;
        pos_d        = pos_q;
        state_d      = state_q;
        pend_valid_d = pend_valid_q;
        pend_mode_d  = pend_mode_q;

        if (!pause) begin
            div_d = div_q + 1'b1;
        end

        // Accept only while the slot is empty; an apply can never coincide with an accept.
        if (req.mode_valid && !pend_valid_q) begin
            pend_valid_d = 1'b1;
            pend_mode_d  = req.mode;
        end

        if (step) begin
            if (pend_valid_q) begin
                // Apply restarts the requested mode regardless of current position.
                pend_valid_d = 1'b0;
                case (pend_mode_q)
                    2'd0: begin
                        state_d = StFwd;
                        pos_d   = '0;
                    end
                    2'd1: begin
                        state_d = StRev;
                        pos_d   = POS_MAX;
                    end
                    2'd2: begin
                        state_d = StBounceUp;
                        pos_d   = '0;
                    end
                    default: begin
                        state_d = StBlinkOn;
                    end
                endcase
            end else begin
                case (state_q)
                    StFwd: begin
                        pos_d = (pos_q == POS_MAX) ? '0 : pos_q + POS_ONE;
                    end
                    StRev: begin
                        pos_d = (pos_q == '0) ? POS_MAX : pos_q - POS_ONE;
                    end
                    StBounceUp: begin
                        // Turn around on arrival so the end LED is shown only once.
                        pos_d = pos_q + POS_ONE;
                        if (pos_d == POS_MAX) begin
                            state_d = StBounceDn;
                        end
                    end
                    StBounceDn: begin
                        pos_d = pos_q - POS_ONE;
                        if (pos_d == '0) begin
                            state_d = StBounceUp;
                        end
                    end
                    StBlinkOn:  state_d = StBlinkOff;
                    StBlinkOff: state_d = StBlinkOn;
                    default:    state_d = StFwd;
                endcase
            end
        end
    end

    // LED drive decoded from the next state so it updates on the same edge as the step.
    always_comb begin
        led_d = '0;
        case (state_d)
            StBlinkOn:  led_d = '1;
            StBlinkOff: led_d = '0;
            default:    led_d[pos_d] = 1'b1;
        endcase
    end

    // State registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q        <= '0;
            pos_q        <= '0;
            state_q      <= StFwd;
            pend_valid_q <= 1'b0;
            pend_mode_q  <= '0;
            led_q        <= NUM_LED'(1);
            step_tick_q  <= 1'b0;
        end else begin
            div_q        <= div_d;
            pos_q        <= pos_d;
            state_q      <= state_d;
            pend_valid_q <= pend_valid_d;
            pend_mode_q  <= pend_mode_d;
            led_q        <= led_d;
            step_tick_q  <= step;
        end
    end

`ifdef LED_HEARTBEAT_EN
    logic cycle_done;
    logic led_pwr_q;

    // A pattern cycle completes on a plain (non-apply) step that wraps the pattern.
    always_comb begin
        cycle_done = 1'b0;
        if (step && !pend_valid_q) begin
            case (state_q)
                StFwd:      cycle_done = (pos_q == POS_MAX);
                StRev:      cycle_done = (pos_q == '0);
                StBounceDn: cycle_done = (pos_q == POS_ONE);
                StBlinkOff: cycle_done = 1'b1;
                default:    cycle_done = 1'b0;
            endcase
        end
    end

    // Heartbeat toggle register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            led_pwr_q <= 1'b1;
        end else if (cycle_done) begin
            led_pwr_q <= ~led_pwr_q;
        end
    end

    assign led_pwr = led_pwr_q;
`else
    assign led_pwr = 1'b1;
`endif

endmodule

// File: tb/tb_led_seq_ctrl.sv
// Testbench for led_seq_ctrl (DIV_W=2, NUM_LED=4: one step every 4 clocks).
// Directed scenarios with literal expectations, then randomized stimulus, all cross-checked
// every cycle against a pattern model expressed as (mode, steps since mode start).
module tb_led_seq_ctrl;

    localparam int unsigned DIV_W   = 2;
    localparam int unsigned NUM_LED = 4;
    localparam int          DIV_N   = 1 << DIV_W;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               pause = 1'b0;
    logic [NUM_LED-1:0] led;
    logic               led_pwr;
    logic               step_tick;

    led_seq_ctrl_if bus ();

    led_seq_ctrl #(
        .DIV_W   (DIV_W),
        .NUM_LED (NUM_LED)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (bus),
        .pause     (pause),
        .led       (led),
        .led_pwr   (led_pwr),
        .step_tick (step_tick)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int m_div, m_mode, m_k, m_pend_mode;
    bit m_pend, m_tick, m_pwr, m_step, m_acc;

    function automatic int period(input int md);
        case (md)
            2:       return 2 * NUM_LED - 2;
            3:       return 2;
            default: return NUM_LED;
        endcase
    endfunction

    // Expected LEDs for a mode after k steps since it started.
    function automatic logic [NUM_LED-1:0] exp_led(input int md, input int k);
        int p;
        logic [NUM_LED-1:0] one;
        one = 1;
        case (md)
            0: p = k % NUM_LED;
            1: p = NUM_LED - 1 - (k % NUM_LED);
            2: begin
                p = k % (2 * NUM_LED - 2);
                if (p >= NUM_LED) p = 2 * NUM_LED - 2 - p;
            end
            default: return (k % 2 == 0) ? '1 : '0;
        endcase
        return one << p;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_div = 0; m_mode = 0; m_k = 0; m_pend = 0; m_pend_mode = 0;
            m_tick = 0; m_pwr = 1;
        end else begin
            m_step = !pause && (m_div == DIV_N - 1);
            m_acc  = bus.mode_valid && !m_pend;
            m_tick = m_step;
            if (!pause) m_div = (m_div + 1) % DIV_N;
            if (m_step) begin
                if (m_pend) begin
                    m_mode = m_pend_mode;
                    m_k    = 0;
                    m_pend = 0;
                end else begin
                    m_k++;
`ifdef LED_HEARTBEAT_EN
                    if (m_k % period(m_mode) == 0) m_pwr = !m_pwr;
`endif
                end
            end
            if (m_acc) begin
                m_pend      = 1;
                m_pend_mode = int'(bus.mode);
            end
        end
    end

    // Per-cycle compare against the model.
    always @(negedge clk) begin
        if (rst_n && chk_en) begin
            check("cyc_led",   led,            exp_led(m_mode, m_k));
            check("cyc_ready", bus.mode_ready, !m_pend);
            check("cyc_tick",  step_tick,      m_tick);
            check("cyc_pwr",   led_pwr,        m_pwr);
        end
    end

    // ---------------- directed + random stimulus ----------------
    logic [3:0] exp_fwd [5] = '{4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010};
    logic [3:0] exp_bnc [7] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0100, 4'b0010, 4'b0001};
    logic [3:0] exp_hb_led [8] = '{4'b0010, 4'b0100, 4'b1000, 4'b0001,
                                   4'b0010, 4'b0100, 4'b1000, 4'b0001};
`ifdef LED_HEARTBEAT_EN
    logic exp_hb_pwr [8] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
`else
    logic exp_hb_pwr [8] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
`endif
    int c;
    int ticks;

    task automatic wait_step(output int cyc);
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (step_tick !== 1'b1 && cyc < 50);
        if (step_tick !== 1'b1) check("step_timeout", step_tick, 1);
    endtask

    task automatic step_led(input string name, input logic [3:0] exp);
        int cc;
        wait_step(cc);
        check(name, led, exp);
    endtask

    initial begin
        bus.mode_valid = 1'b0;
        bus.mode       = 2'd0;
        pause          = 1'b0;
        rst_n          = 1'b0;
        #12;
        check("rst_led",   led, 4'b0001);
        check("rst_ready", bus.mode_ready, 1);
        check("rst_tick",  step_tick, 0);
        check("rst_pwr",   led_pwr, 1);
        @(negedge clk);
        rst_n  = 1'b1;
        chk_en = 1'b1;

        // FWD from reset, step every 4th cycle.
        for (int i = 0; i < 5; i++) begin
            wait_step(c);
            check("fwd_interval", c, 4);
            check("fwd_led", led, exp_fwd[i]);
        end

        // BOUNCE request mid-interval.
        @(negedge clk);
        bus.mode_valid = 1'b1;
        bus.mode       = 2'd2;
        @(negedge clk);
        check("bnc_ready_low", bus.mode_ready, 0);
        bus.mode_valid = 1'b0;
        wait_step(c);
        check("bnc_apply_led", led, exp_bnc[0]);
        check("bnc_ready_back", bus.mode_ready, 1);
        for (int i = 1; i < 7; i++) step_led("bnc_led", exp_bnc[i]);

        // FWD pending, REV held while not ready, accepted after apply.
        @(negedge clk);
        bus.mode_valid = 1'b1;
        bus.mode       = 2'd0;
        @(negedge clk);
        check("hold_ready_low", bus.mode_ready, 0);
        bus.mode = 2'd1;
        wait_step(c);
        check("hold_fwd_led", led, 4'b0001);
        check("hold_ready_free", bus.mode_ready, 1);
        @(negedge clk);
        check("hold_accepted", bus.mode_ready, 0);
        bus.mode_valid = 1'b0;
        step_led("rev_apply_led", 4'b1000);
        step_led("rev_led", 4'b0100);

        // BLINK, then pause.
        @(negedge clk);
        bus.mode_valid = 1'b1;
        bus.mode       = 2'd3;
        @(negedge clk);
        bus.mode_valid = 1'b0;
        step_led("blink_on", 4'b1111);
        step_led("blink_off", 4'b0000);
        step_led("blink_on2", 4'b1111);
        pause = 1'b1;
        ticks = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (step_tick === 1'b1) ticks++;
        end
        check("pause_ticks", ticks, 0);
        check("pause_led", led, 4'b1111);
        pause = 1'b0;
        wait_step(c);
        check("resume_interval", c, 4);
        check("resume_led", led, 4'b0000);

        // Reset mid-BOUNCE with a request pending.
        @(negedge clk);
        bus.mode_valid = 1'b1;
        bus.mode       = 2'd2;
        @(negedge clk);
        bus.mode_valid = 1'b0;
        step_led("bnc2_apply", 4'b0001);
        step_led("bnc2_led", 4'b0010);
        @(negedge clk);
        bus.mode_valid = 1'b1;
        bus.mode       = 2'd1;
        @(negedge clk);
        bus.mode_valid = 1'b0;
        check("pend_ready_low", bus.mode_ready, 0);
        #2 rst_n = 1'b0;
        #1;
        check("arst_led",   led, 4'b0001);
        check("arst_ready", bus.mode_ready, 1);
        check("arst_pwr",   led_pwr, 1);
        check("arst_tick",  step_tick, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Eight FWD steps: heartbeat (if built) toggles on the 4th and 8th.
        for (int i = 0; i < 8; i++) begin
            wait_step(c);
            check("hb_interval", c, 4);
            check("hb_led", led, exp_hb_led[i]);
            check("hb_pwr", led_pwr, exp_hb_pwr[i]);
        end

        // Randomized requests and pauses.
        for (int i = 0; i < 1500; i++) begin
            @(negedge clk);
            pause          = ($urandom_range(0, 7) == 0);
            bus.mode_valid = ($urandom_range(0, 5) == 0);
            bus.mode       = 2'($urandom_range(0, 3));
        end
        @(negedge clk);
        pause          = 1'b0;
        bus.mode_valid = 1'b0;
        repeat (8) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
